// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// Hits are answered combinationally from the frame array in IDLE; misses
// latch the word address and fetch it from memory in FETCH.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_direct #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int FRAMES = 1 << INDEX_BITS;
  localparam int TW     = 30 - INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state, next_state;
  logic [FRAMES-1:0]       valid;
  logic [TW-1:0]           tags  [FRAMES];
  logic [31:0]             data  [FRAMES];
  logic [29:0]             miss_addr;
  logic                    flush_pend;

  logic [INDEX_BITS-1:0]   idx;
  logic [TW-1:0]           tag;
  logic [INDEX_BITS-1:0]   fidx;
  logic [TW-1:0]           ftag;
  logic                    lookup_hit;
  logic                    miss;
  logic                    fill;
  logic                    unused_bits;

  assign idx         = imemaddr[INDEX_BITS+1:2];
  assign tag         = imemaddr[31:INDEX_BITS+2];
  assign fidx        = miss_addr[INDEX_BITS-1:0];
  assign ftag        = miss_addr[29:INDEX_BITS];
  assign unused_bits = ^imemaddr[1:0];

  // Lookup, miss detection and memory-side outputs.
  always_comb begin
    lookup_hit = valid[idx] && (tags[idx] == tag);
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss       = 1'b0;
    fill       = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (imemREN) begin
          // A flush in this cycle invalidates the array, so no hit is reported.
          if (lookup_hit && !flush) begin
            ihit     = 1'b1;
            imemload = data[idx];
          end else begin
            miss       = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
        if (!iwait) begin
          // A flush seen at any point during the fetch discards the data.
          fill       = !flush && !flush_pend;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Remember a flush that arrived while waiting on memory.
  always_ff @(posedge CLK) begin
    if (RST)
      flush_pend <= 1'b0;
    else if (state == FETCH && iwait && flush)
      flush_pend <= 1'b1;
    else if (state != FETCH || !iwait)
      flush_pend <= 1'b0;
  end

  // Latch the missing word address so the fill ignores later imemaddr changes.
  always_ff @(posedge CLK) begin
    if (miss) miss_addr <= imemaddr[31:2];
  end

  // Valid bits: reset and flush clear all, fill sets one.
  always_ff @(posedge CLK) begin
    if (RST || flush)
      valid <= '0;
    else if (fill)
      valid[fidx] <= 1'b1;
  end

  // Tag and data arrays are not reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tags[fidx] <= ftag;
      data[fidx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && hit_count != '1)  hit_count  <= hit_count + 32'd1;
      if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: fills, hits, conflicts, flush and reset.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  icache_direct #(.INDEX_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // Miss on a, memory busy for 'waits' cycles, then returns d; expect hit after.
  task automatic fetch_miss(input logic [31:0] a, input int unsigned waits,
                            input logic [31:0] d);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; flush = 1'b0;
    @(negedge CLK);
    chk("miss_ihit", {31'b0, ihit}, 32'd0);
    chk("miss_iren", {31'b0, iREN}, 32'd0);
    chk("miss_load", imemload, 32'd0);
    next_cycle();
    for (int unsigned i = 0; i < waits; i++) begin
      imemaddr = 32'h0000_1234 + (i << 2);
      @(negedge CLK);
      chk("wait_iren", {31'b0, iREN}, 32'd1);
      chk("wait_iaddr", iaddr, {a[31:2], 2'b00});
      chk("wait_ihit", {31'b0, ihit}, 32'd0);
      next_cycle();
    end
    iwait = 1'b0; iload = d;
    @(negedge CLK);
    chk("done_iren", {31'b0, iREN}, 32'd1);
    chk("done_iaddr", iaddr, {a[31:2], 2'b00});
    next_cycle();
    iwait = 1'b1; iload = '0; imemaddr = a;
    @(negedge CLK);
    chk("fill_ihit", {31'b0, ihit}, 32'd1);
    chk("fill_load", imemload, d);
    chk("fill_iren", {31'b0, iREN}, 32'd0);
    next_cycle();
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    iwait = 1'b1; iload = '0;
    next_cycle(); next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_load", imemload, 32'd0);
    next_cycle();

    // First fill with three busy cycles and a wandering imemaddr.
    fetch_miss(32'h0000_0040, 3, 32'h0050_0093);

    // Same-cycle hit.
    imemREN = 1'b1; imemaddr = 32'h0000_0043;
    @(negedge CLK);
    chk("rehit_ihit", {31'b0, ihit}, 32'd1);
    chk("rehit_load", imemload, 32'h0050_0093);
    chk("rehit_iren", {31'b0, iREN}, 32'd0);
    next_cycle();

    // Conflict eviction on index 0.
    fetch_miss(32'h0000_0080, 1, 32'hAAAA_5555);
    fetch_miss(32'h0000_0040, 0, 32'h0050_0093);

`ifdef ICACHE_STATS_EN
    imemREN = 1'b0;
    @(negedge CLK);
    chk("miss_count", miss_count, 32'd3);
    chk("hit_count", hit_count, 32'd4);
    next_cycle();
`endif

    // Idle with no request.
    imemREN = 1'b0;
    @(negedge CLK);
    chk("idle_ihit", {31'b0, ihit}, 32'd0);
    chk("idle_iren", {31'b0, iREN}, 32'd0);
    chk("idle_iaddr", iaddr, 32'd0);
    next_cycle();

    // Flush during a busy FETCH of 0x44: data discarded.
    imemREN = 1'b1; imemaddr = 32'h0000_0044; iwait = 1'b1;
    @(negedge CLK);
    chk("f44_miss", {31'b0, ihit}, 32'd0);
    next_cycle();
    flush = 1'b1;
    @(negedge CLK);
    chk("f44_iren", {31'b0, iREN}, 32'd1);
    next_cycle();
    flush = 1'b0; iwait = 1'b0; iload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("f44_done", {31'b0, iREN}, 32'd1);
    next_cycle();
    iwait = 1'b1;
    fetch_miss(32'h0000_0044, 0, 32'h0000_0011);
    fetch_miss(32'h0000_0040, 0, 32'h0050_0093);

    // Flush in the completing cycle also suppresses the fill.
    imemREN = 1'b1; imemaddr = 32'h0000_0048; iwait = 1'b1;
    @(negedge CLK);
    chk("f48_miss", {31'b0, ihit}, 32'd0);
    next_cycle();
    iwait = 1'b0; flush = 1'b1; iload = 32'h1234_5678;
    @(negedge CLK);
    chk("f48_iren", {31'b0, iREN}, 32'd1);
    next_cycle();
    flush = 1'b0; iwait = 1'b1;
    fetch_miss(32'h0000_0048, 0, 32'h0000_0022);

    // Flush in IDLE masks a would-be hit.
    imemREN = 1'b1; imemaddr = 32'h0000_0048; flush = 1'b1;
    @(negedge CLK);
    chk("fidle_ihit", {31'b0, ihit}, 32'd0);
    chk("fidle_load", imemload, 32'd0);
    next_cycle();
    flush = 1'b0; imemREN = 1'b0; iwait = 1'b0;
    next_cycle();
    iwait = 1'b1;

    // Reset in the middle of a FETCH.
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    @(negedge CLK);
    chk("rf_miss", {31'b0, ihit}, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("rf_iren", {31'b0, iREN}, 32'd1);
    next_cycle();
    RST = 1'b1; imemREN = 1'b0;
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    chk("rf_iren0", {31'b0, iREN}, 32'd0);
    chk("rf_iaddr0", iaddr, 32'd0);
    next_cycle();
    fetch_miss(32'h0000_0040, 0, 32'h0050_0093);
    fetch_miss(32'h0000_0044, 0, 32'h0000_0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
